// File: rtl/lieat_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lieat_axi_arbiter
// Brief    : Merges the IFU read port and the LSU read/write port onto one
//            single-beat AXI4 master; round-robin read grant, owner-routed
//            responses, one outstanding read and one outstanding write.
// Revision : 1.0 - initial release
// ============================================================================
module lieat_axi_arbiter #(
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rstn,
    // IFU read port
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    // LSU read port
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    // LSU write port
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic [2:0]  lsu_awsize,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,
    // AXI4 master
    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [7:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]  r_rd_state, w_rd_next;
    logic [1:0]  r_wr_state, w_wr_next;
    logic        r_rd_owner;
    logic        r_rr_last;
    logic        r_aw_done, r_w_done;

    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;

    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic [3:0]  r_awid;
    logic [7:0]  r_awlen;
    logic [2:0]  r_awsize;
    logic [1:0]  r_awburst;
    logic        r_wvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wlast;

    logic w_lsu_rd_ok, w_grant_ifu, w_grant_lsu, w_wr_go;
    logic w_lsu_rd_busy, w_aw_fin, w_w_fin;
    logic w_unused;

    // An LSU read may not overlap an LSU write in either direction.
    assign w_lsu_rd_busy = r_rd_owner & (r_rd_state != R_IDLE);
    assign w_lsu_rd_ok   = lsu_arvalid & (r_wr_state == W_IDLE);
    assign w_grant_ifu   = (r_rd_state == R_IDLE) & ifu_arvalid & (~w_lsu_rd_ok | r_rr_last);
    assign w_grant_lsu   = (r_rd_state == R_IDLE) & w_lsu_rd_ok & ~w_grant_ifu;
    assign w_wr_go       = (r_wr_state == W_IDLE) & lsu_awvalid & lsu_wvalid
                           & ~w_lsu_rd_busy & ~w_grant_lsu;

    assign w_aw_fin = r_aw_done | (r_awvalid & io_master_awready);
    assign w_w_fin  = r_w_done  | (r_wvalid  & io_master_wready);

    assign ifu_arready = rstn & w_grant_ifu;
    assign lsu_arready = rstn & w_grant_lsu;
    assign lsu_awready = rstn & w_wr_go;
    assign lsu_wready  = rstn & w_wr_go;

    assign ifu_rvalid       = (r_rd_state == R_DATA) & ~r_rd_owner & io_master_rvalid;
    assign lsu_rvalid       = (r_rd_state == R_DATA) &  r_rd_owner & io_master_rvalid;
    assign io_master_rready = (r_rd_state == R_DATA) & (r_rd_owner ? lsu_rready : ifu_rready);
    assign ifu_rdata        = io_master_rdata;
    assign ifu_rresp        = io_master_rresp;
    assign lsu_rdata        = io_master_rdata;
    assign lsu_rresp        = io_master_rresp;

    assign lsu_bvalid       = (r_wr_state == W_RESP) & io_master_bvalid;
    assign io_master_bready = (r_wr_state == W_RESP) & lsu_bready;
    assign lsu_bresp        = io_master_bresp;

    assign io_master_arvalid = r_arvalid;
    assign io_master_araddr  = r_araddr;
    assign io_master_arid    = r_arid;
    assign io_master_arlen   = r_arlen;
    assign io_master_arsize  = r_arsize;
    assign io_master_arburst = r_arburst;
    assign io_master_awvalid = r_awvalid;
    assign io_master_awaddr  = r_awaddr;
    assign io_master_awid    = r_awid;
    assign io_master_awlen   = r_awlen;
    assign io_master_awsize  = r_awsize;
    assign io_master_awburst = r_awburst;
    assign io_master_wvalid  = r_wvalid;
    assign io_master_wdata   = r_wdata;
    assign io_master_wstrb   = {4'b0000, r_wstrb};
    assign io_master_wlast   = r_wlast;

    // Response ids are not checked: single outstanding access per direction.
    assign w_unused = ^{io_master_bid, io_master_rid};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_grant_ifu | w_grant_lsu) w_rd_next = R_ADDR;
            R_ADDR:  if (io_master_arready) w_rd_next = R_DATA;
            R_DATA:  if (io_master_rvalid & io_master_rready & io_master_rlast) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_wr_go) w_wr_next = W_REQ;
            W_REQ:   if (w_aw_fin & w_w_fin) w_wr_next = W_RESP;
            W_RESP:  if (io_master_bvalid & lsu_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_owner <= 1'b0;
            r_rr_last  <= 1'b1;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arid     <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
        end else if (w_grant_ifu | w_grant_lsu) begin
            r_rd_owner <= w_grant_lsu;
            r_rr_last  <= w_grant_lsu;
            r_arvalid  <= 1'b1;
            r_araddr   <= w_grant_lsu ? lsu_araddr : ifu_araddr;
            r_arid     <= w_grant_lsu ? LSU_ID : IFU_ID;
            r_arlen    <= 8'd0;
            r_arsize   <= w_grant_lsu ? lsu_arsize : 3'b010;
            r_arburst  <= 2'b01;
        end else if (r_arvalid & io_master_arready) begin
            r_arvalid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
        end else if (w_wr_go) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= lsu_awaddr;
            r_awid    <= LSU_ID;
            r_awlen   <= 8'd0;
            r_awsize  <= lsu_awsize;
            r_awburst <= 2'b01;
            r_wdata   <= lsu_wdata;
            r_wstrb   <= lsu_wstrb;
            r_wlast   <= 1'b1;
        end else if (r_wr_state == W_REQ) begin
            // AW and W channels complete independently.
            if (r_awvalid & io_master_awready) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (r_wvalid & io_master_wready) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lieat_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lieat_axi_arbiter
// Brief    : Self-checking bench: table of read arbitration vectors plus
//            directed write, stall, write/read-ordering and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lieat_axi_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_awsize;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        io_master_awready, io_master_awvalid;
    logic [31:0] io_master_awaddr;
    logic [3:0]  io_master_awid;
    logic [7:0]  io_master_awlen;
    logic [2:0]  io_master_awsize;
    logic [1:0]  io_master_awburst;
    logic        io_master_wready, io_master_wvalid, io_master_wlast;
    logic [31:0] io_master_wdata;
    logic [7:0]  io_master_wstrb;
    logic        io_master_bready, io_master_bvalid;
    logic [1:0]  io_master_bresp;
    logic [3:0]  io_master_bid;
    logic        io_master_arready, io_master_arvalid;
    logic [31:0] io_master_araddr;
    logic [3:0]  io_master_arid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rready, io_master_rvalid, io_master_rlast;
    logic [1:0]  io_master_rresp;
    logic [31:0] io_master_rdata;
    logic [3:0]  io_master_rid;

    int n_tests = 0;
    int n_fail  = 0;

    lieat_axi_arbiter #(.IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
        .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic [2:0]  lsu_size;
        logic        exp_lsu;
        logic [31:0] data;
    } rd_vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Complete one read: arbitration, AR channel, single-beat R channel.
    task automatic do_read(input rd_vec_t v);
        int k;
        logic [31:0] exp_addr;
        exp_addr = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
        ifu_arvalid = v.ifu_v;  ifu_araddr = v.ifu_addr;
        lsu_arvalid = v.lsu_v;  lsu_araddr = v.lsu_addr;  lsu_arsize = v.lsu_size;
        #1;
        k = 0;
        while (!(ifu_arready | lsu_arready) && k < 10) begin
            step();
            k++;
        end
        chk("grant_within_bound", 64'(k < 10), 64'd1);
        chk("ifu_arready", 64'(ifu_arready), 64'(!v.exp_lsu));
        chk("lsu_arready", 64'(lsu_arready), 64'(v.exp_lsu));
        step();
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        #1;
        chk("arvalid", 64'(io_master_arvalid), 64'd1);
        chk("arid", 64'(io_master_arid), v.exp_lsu ? 64'd1 : 64'd0);
        chk("araddr", 64'(io_master_araddr), 64'(exp_addr));
        chk("arsize", 64'(io_master_arsize), v.exp_lsu ? 64'(v.lsu_size) : 64'd2);
        chk("arlen", 64'(io_master_arlen), 64'd0);
        chk("arburst", 64'(io_master_arburst), 64'd1);
        chk("arready_pulse", 64'(ifu_arready | lsu_arready), 64'd0);
        io_master_arready = 1'b1;
        step();
        io_master_arready = 1'b0;
        chk("arvalid_drop", 64'(io_master_arvalid), 64'd0);
        io_master_rvalid = 1'b1;  io_master_rdata = v.data;
        io_master_rlast  = 1'b1;  io_master_rresp = 2'b00;
        ifu_rready = 1'b1;        lsu_rready = 1'b1;
        #1;
        chk("ifu_rvalid", 64'(ifu_rvalid), 64'(!v.exp_lsu));
        chk("lsu_rvalid", 64'(lsu_rvalid), 64'(v.exp_lsu));
        chk("rdata", v.exp_lsu ? 64'(lsu_rdata) : 64'(ifu_rdata), 64'(v.data));
        chk("io_rready", 64'(io_master_rready), 64'd1);
        step();
        io_master_rvalid = 1'b0;  io_master_rlast = 1'b0;
        ifu_rready = 1'b0;        lsu_rready = 1'b0;
    endtask

    rd_vec_t vecs[7];
    rd_vec_t tmp;
    logic [31:0] held_addr;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // ifu_v lsu_v ifu_addr lsu_addr size exp_lsu data
        vecs[0] = '{1'b1, 1'b1, 32'h8000_0004, 32'h0000_1000, 3'd2, 1'b0, 32'h1111_1111};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0008, 32'h0000_1004, 3'd1, 1'b1, 32'h2222_2222};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_000C, 32'h0000_1008, 3'd0, 1'b0, 32'h3333_3333};
        vecs[3] = '{1'b0, 1'b1, 32'h0,         32'h0000_2000, 3'd2, 1'b1, 32'h4444_4444};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         3'd0, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0010, 32'h0000_2004, 3'd2, 1'b1, 32'h5555_5555};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h0000_2008, 3'd1, 1'b1, 32'h6666_6666};

        rstn = 1'b0;
        ifu_arvalid = 0; ifu_araddr = 0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arsize = 0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awsize = 0;
        lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_bready = 0;
        io_master_awready = 0; io_master_wready = 0;
        io_master_bvalid = 0; io_master_bresp = 0; io_master_bid = 0;
        io_master_arready = 0; io_master_rvalid = 0; io_master_rresp = 0;
        io_master_rdata = 0; io_master_rlast = 0; io_master_rid = 0;
        repeat (3) step();
        rstn = 1'b1;
        #1;

        // Reset state
        chk("rst_arvalid", 64'(io_master_arvalid), 64'd0);
        chk("rst_awvalid", 64'(io_master_awvalid), 64'd0);
        chk("rst_wvalid", 64'(io_master_wvalid), 64'd0);
        chk("rst_araddr", 64'(io_master_araddr), 64'd0);
        chk("rst_arburst", 64'(io_master_arburst), 64'd0);
        chk("rst_wstrb", 64'(io_master_wstrb), 64'd0);
        chk("rst_wlast", 64'(io_master_wlast), 64'd0);
        chk("rst_readies", 64'({ifu_arready, lsu_arready, lsu_awready, lsu_wready,
                                io_master_rready, io_master_bready}), 64'd0);

        // Read arbitration table
        for (int i = 0; i < 7; i++) do_read(vecs[i]);

        // LSU write, AW accepted one cycle before W
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h10; lsu_awsize = 3'd2;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b0011;
        #1;
        chk("wr_awready", 64'(lsu_awready), 64'd1);
        chk("wr_wready", 64'(lsu_wready), 64'd1);
        step();
        lsu_awvalid = 0; lsu_wvalid = 0;
        #1;
        chk("wr_valids", 64'({io_master_awvalid, io_master_wvalid}), 64'h3);
        chk("wr_awaddr", 64'(io_master_awaddr), 64'h10);
        chk("wr_wdata", 64'(io_master_wdata), 64'h1234_5678);
        chk("wr_wstrb", 64'(io_master_wstrb), 64'h03);
        chk("wr_wlast", 64'(io_master_wlast), 64'd1);
        chk("wr_awid", 64'(io_master_awid), 64'd1);
        chk("wr_awlen_burst", 64'({io_master_awlen, io_master_awburst}), 64'h001);
        chk("wr_awready_pulse", 64'(lsu_awready), 64'd0);
        io_master_awready = 1;
        step();
        io_master_awready = 0;
        chk("wr_aw_drop", 64'({io_master_awvalid, io_master_wvalid}), 64'h1);
        io_master_wready = 1;
        step();
        io_master_wready = 0;
        chk("wr_w_drop", 64'(io_master_wvalid), 64'd0);
        io_master_bvalid = 1; io_master_bresp = 2'b00; lsu_bready = 1;
        #1;
        chk("wr_bvalid", 64'(lsu_bvalid), 64'd1);
        chk("wr_bresp", 64'(lsu_bresp), 64'd0);
        chk("wr_bready", 64'(io_master_bready), 64'd1);
        step();
        io_master_bvalid = 0; lsu_bready = 0;
        #1;
        chk("wr_bvalid_idle", 64'(lsu_bvalid), 64'd0);

        // Slave stalls arready for 5 cycles while the LSU also requests
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
        #1;
        chk("stall_grant", 64'(ifu_arready), 64'd1);
        step();
        ifu_arvalid = 0; lsu_arvalid = 1; lsu_araddr = 32'h3000; lsu_arsize = 3'd2;
        held_addr = 32'h8000_0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_arvalid", 64'(io_master_arvalid), 64'd1);
            chk("stall_araddr", 64'(io_master_araddr), 64'(held_addr));
            chk("stall_no_grant", 64'({ifu_arready, lsu_arready}), 64'd0);
            step();
        end
        lsu_arvalid = 0;
        io_master_arready = 1;
        step();
        io_master_arready = 0;
        io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = 32'hCAFE_0001; ifu_rready = 1;
        #1;
        chk("stall_rdata", 64'(ifu_rdata), 64'hCAFE_0001);
        chk("stall_rvalid", 64'(ifu_rvalid), 64'd1);
        step();
        io_master_rvalid = 0; io_master_rlast = 0; ifu_rready = 0;

        // Write outstanding: only the IFU may read until after the B handshake
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h20; lsu_wdata = 32'hA5A5_A5A5;
        lsu_wstrb = 4'hF;
        #1;
        chk("ord_wgrant", 64'(lsu_awready), 64'd1);
        step();
        lsu_awvalid = 0; lsu_wvalid = 0;
        io_master_awready = 1; io_master_wready = 1;
        step();
        io_master_awready = 0; io_master_wready = 0;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0200;
        lsu_arvalid = 1; lsu_araddr = 32'h4000; lsu_arsize = 3'd2;
        #1;
        chk("ord_ifu_grant", 64'(ifu_arready), 64'd1);
        chk("ord_lsu_blocked", 64'(lsu_arready), 64'd0);
        step();
        ifu_arvalid = 0;
        chk("ord_arid", 64'(io_master_arid), 64'd0);
        io_master_arready = 1;
        step();
        io_master_arready = 0;
        io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = 32'hBEEF_0002; ifu_rready = 1;
        #1;
        chk("ord_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
        chk("ord_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        step();
        io_master_rvalid = 0; io_master_rlast = 0; ifu_rready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ord_lsu_wait", 64'(lsu_arready), 64'd0);
            step();
        end
        io_master_bvalid = 1; lsu_bready = 1;
        #1;
        chk("ord_b_hs", 64'(lsu_bvalid & io_master_bready), 64'd1);
        chk("ord_lsu_at_b", 64'(lsu_arready), 64'd0);
        step();
        io_master_bvalid = 0; lsu_bready = 0;
        #1;
        chk("ord_lsu_after_b", 64'(lsu_arready), 64'd1);
        step();
        lsu_arvalid = 0;
        chk("ord_lsu_arid", 64'(io_master_arid), 64'd1);
        chk("ord_lsu_araddr", 64'(io_master_araddr), 64'h4000);
        io_master_arready = 1;
        step();
        io_master_arready = 0;
        io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = 32'h0000_7777; lsu_rready = 1;
        #1;
        chk("ord_lsu_rdata", 64'(lsu_rvalid ? lsu_rdata : 32'h0), 64'h7777);
        step();
        io_master_rvalid = 0; io_master_rlast = 0; lsu_rready = 0;

        // Reset pulse while a read is in its data phase
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0300;
        step();
        ifu_arvalid = 0;
        io_master_arready = 1;
        step();
        io_master_arready = 0;
        rstn = 0;
        step();
        rstn = 1;
        ifu_rready = 1;
        #1;
        chk("rst_mid_valids", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid,
                                   ifu_rvalid, lsu_rvalid}), 64'd0);
        chk("rst_mid_rready", 64'(io_master_rready), 64'd0);
        ifu_rready = 0;
        tmp = '{1'b1, 1'b0, 32'h8000_0400, 32'h0, 3'd0, 1'b0, 32'h0BAD_F00D};
        do_read(tmp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lieat_axi_arbiter.md
# lieat_axi_arbiter

Two-master AXI arbiter inside `lieat_core` that merges the instruction-fetch (IFU) read port and the load/store (LSU) read/write port onto the single `io_master_*` AXI4 bus, which feeds `lieat_axi_slave` and then `lieat_sram`. It allows one outstanding read and one outstanding write, all single-beat. It selects the read master round-robin and routes each response back by the latched owner.

## Interface
- `IFU_ID`, default 4'd0: `io_master_arid` driven for IFU reads.
- `LSU_ID`, default 4'd1: `io_master_arid`/`io_master_awid` driven for LSU accesses.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `ifu_arvalid`/`ifu_arready`  in/out  1/1  IFU read-address handshake; `ifu_araddr` in 32.
- `ifu_rvalid`/`ifu_rready`  out/in  1/1  IFU read-data handshake; `ifu_rdata` out 32; `ifu_rresp` out 2.
- `lsu_arvalid`/`lsu_arready`  in/out  1/1; `lsu_araddr` in 32; `lsu_arsize` in 3.
- `lsu_rvalid`/`lsu_rready`  out/in  1/1; `lsu_rdata` out 32; `lsu_rresp` out 2.
- `lsu_awvalid`/`lsu_awready`  in/out  1/1; `lsu_awaddr` in 32; `lsu_awsize` in 3.
- `lsu_wvalid`/`lsu_wready`  in/out  1/1; `lsu_wdata` in 32; `lsu_wstrb` in 4.
- `lsu_bvalid`/`lsu_bready`  out/in  1/1; `lsu_bresp` out 2.
- `io_master_aw{ready,valid,addr,id,len,size,burst}`  in/out  1,1,32,4,8,3,2  write address.
- `io_master_w{ready,valid,data,strb,last}`  in/out  1,1,32,8,1  write data.
- `io_master_b{ready,valid,resp,id}`  out/in  1,1,2,4  write response.
- `io_master_ar{ready,valid,addr,id,len,size,burst}`  in/out  1,1,32,4,8,3,2  read address.
- `io_master_r{ready,valid,resp,data,last,id}`  out/in  1,1,2,32,1,4  read data.

## Operation
- **Read FSM** states: R_IDLE, R_ADDR, R_DATA. Register `rd_owner` holds 0 for IFU and 1 for LSU. Register `rr_last` holds the last granted read master.
- **R_IDLE**
  - If exactly one requester is valid, grant it. If both are valid, grant the one that is not `rr_last`.
  - LSU requests are not eligible while the write FSM is not in W_IDLE.
  - On grant: pulse that master's `*_arready` for 1 cycle, latch addr, size and owner, update `rr_last`, and go to R_ADDR.
- **R_ADDR**
  - `io_master_arvalid`=1 with the latched fields. IFU reads use size 3'b010.
  - Every read drives `arlen`=0 and `arburst`=2'b01.
  - On `io_master_arready`, go to R_DATA.
- **R_DATA**
  - Owner's `*_rvalid` = `io_master_rvalid`; `io_master_rready` = owner's `*_rready`. `rdata` and `rresp` pass through combinationally.
  - The non-owner's `rvalid` is 0.
  - On `io_master_rvalid & io_master_rready & io_master_rlast`, go to R_IDLE. `rid` is not checked.
- **Write FSM** states: W_IDLE, W_REQ, W_RESP. The LSU is the only writer.
- **W_IDLE**
  - Requires `lsu_awvalid & lsu_wvalid`, and the read FSM must not hold an LSU read.
  - When met: pulse `lsu_awready` and `lsu_wready` together for 1 cycle, latch addr, size, data and strb, and go to W_REQ.
- **W_REQ**
  - `io_master_awvalid` and `io_master_wvalid` are both asserted.
  - Each valid drops independently once its ready is seen. Flags `aw_done`/`w_done` track this.
  - When both are done, go to W_RESP.
  - Fixed fields: `awid`=`LSU_ID`, `awlen`=0, `awburst`=2'b01, `wlast`=1, `wstrb`={4'b0, latched strb}.
- **W_RESP**
  - `lsu_bvalid` = `io_master_bvalid`; `io_master_bready` = `lsu_bready`; `bresp` passes through.
  - On handshake, go to W_IDLE.
- Reads and writes may overlap only when the read owner is the IFU. This keeps LSU memory ordering.

## Timing
- **Reset** (`rstn`=0 at a clock edge):
  - Both FSMs go to idle; `rr_last`=LSU, so the IFU wins the first tie.
  - All `*valid`, `*ready` and `io_master_*ready` outputs are 0.
  - Address, id, data and strb outputs are 0; len=0, size=0, burst=0, wlast=0.
- Reset mid-transaction abandons the transaction. The downstream slave shares `rstn` and is reset in the same cycle.
- **Read latency**
  - Upstream `arready` is high in cycle T; `io_master_arvalid` is high from T+1.
  - Minimum time from request to the owner's `rvalid` is 2 cycles plus slave latency.
  - Back-to-back grant: the next read can be granted in the cycle after the `rlast` handshake.
- **Write latency**
  - `lsu_awready`/`lsu_wready` is high in cycle T; `io_master_awvalid`/`io_master_wvalid` are high from T+1.
- All `io_master` valids are registered and, once asserted, stay stable until the handshake (AXI rule). Address and data stay stable while valid.
- If the IFU and LSU request in the same cycle as a write completes, the LSU read becomes eligible in the next cycle.

## Test plan
- IFU-only read of 0x8000_0000:
  - `ifu_arready` pulses 1 cycle, then `io_master_arvalid`=1 with arid=0, arsize=2, arlen=0.
  - Slave returns 0xDEADBEEF; `ifu_rdata`=0xDEADBEEF and `lsu_rvalid` stays 0.
- IFU and LSU read requests valid in the same cycle after reset, both held:
  - The IFU is granted first, the LSU second (arid=1). The grants then alternate IFU, LSU, IFU.
- LSU write: addr 0x10, data 0x1234_5678, strb 4'b0011.
  - `io_master_wstrb`=8'h03, wlast=1, awid=1.
  - `lsu_bvalid` follows `io_master_bvalid` with bresp=0.
- Slave stalls `arready` for 5 cycles:
  - `io_master_arvalid` and `io_master_araddr` stay constant for all 5 cycles, and no second grant occurs.
- LSU write outstanding (bvalid withheld) while the LSU read and IFU read are both valid:
  - Only the IFU is granted. `lsu_arready` stays 0 until the cycle after the B handshake.
- `rstn` deasserted for 1 cycle while in R_DATA:
  - Next cycle: all valids 0 and both FSMs idle. A new IFU read completes normally.
